// File: rtl/trap_sequencer_pkg.sv
// Shared trap-controller definitions: cause codes, CSR selectors, FSM and event types.
package trap_sequencer_pkg;

    localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
    localparam logic [4:0] EXC_INSTR_FAULT      = 5'd1;
    localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
    localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] EXC_LOAD_FAULT       = 5'd5;
    localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] EXC_STORE_FAULT      = 5'd7;
    localparam logic [4:0] EXC_ECALL_M          = 5'd11;

    // Machine external interrupt: low code bits and full 32-bit cause value.
    localparam logic [4:0]  IRQ_M_EXT_CODE = 5'd11;
    localparam logic [31:0] IRQ_M_EXT      = 32'h8000_000B;

    localparam logic [1:0] CSR_SEL_MEPC    = 2'd0;
    localparam logic [1:0] CSR_SEL_MCAUSE  = 2'd1;
    localparam logic [1:0] CSR_SEL_MTVAL   = 2'd2;
    localparam logic [1:0] CSR_SEL_MSTATUS = 2'd3;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        EVT_EXC,
        EVT_IRQ,
        EVT_MRET
    } trap_evt_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// Commit-side trap bus: event handshakes, drain/redirect control, CSR access and CSR state.
interface trap_sequencer_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned EXC_CODE_W = 5
);
    logic                  exc_valid;
    logic [EXC_CODE_W-1:0] exc_code;
    logic [XLEN-1:0]       exc_pc;
    logic [XLEN-1:0]       exc_tval;
    logic                  exc_ready;
    logic                  irq_pending;
    logic [XLEN-1:0]       commit_pc;
    logic                  mret_valid;
    logic                  mret_ready;
    logic                  lsu_idle;
    logic [XLEN-1:0]       mtvec;
    logic                  csr_wr_en;
    logic [1:0]            csr_wr_sel;
    logic [XLEN-1:0]       csr_wr_data;
    logic                  flush_pipeline;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  redirect_ready;
    logic                  trap_busy;
    logic [XLEN-1:0]       mepc_o;
    logic [XLEN-1:0]       mcause_o;
    logic [XLEN-1:0]       mtval_o;
    logic                  mstatus_mie_o;
    logic                  mstatus_mpie_o;
    logic                  drain_timeout;

    modport master (
        output exc_valid, exc_code, exc_pc, exc_tval, irq_pending, commit_pc,
               mret_valid, lsu_idle, mtvec, csr_wr_en, csr_wr_sel, csr_wr_data,
               redirect_ready,
        input  exc_ready, mret_ready, flush_pipeline, redirect_valid, redirect_pc,
               trap_busy, mepc_o, mcause_o, mtval_o, mstatus_mie_o, mstatus_mpie_o,
               drain_timeout
    );

    modport slave (
        input  exc_valid, exc_code, exc_pc, exc_tval, irq_pending, commit_pc,
               mret_valid, lsu_idle, mtvec, csr_wr_en, csr_wr_sel, csr_wr_data,
               redirect_ready,
        output exc_ready, mret_ready, flush_pipeline, redirect_valid, redirect_pc,
               trap_busy, mepc_o, mcause_o, mtval_o, mstatus_mie_o, mstatus_mpie_o,
               drain_timeout
    );

endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: accepts one exception / interrupt / MRET at a time and
// walks it through drain, flush, trap-CSR update and fetch redirect.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned EXC_CODE_W    = 5,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    trap_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    // mcause keeps only the interrupt flag and the code field
    localparam logic [XLEN-1:0] MCAUSE_MASK =
        {1'b1, {(XLEN-1-EXC_CODE_W){1'b0}}, {EXC_CODE_W{1'b1}}};

    trap_state_t           state, state_next;
    trap_evt_t             evt;
    logic [EXC_CODE_W-1:0] lat_code;
    logic [XLEN-1:0]       lat_pc;
    logic [XLEN-1:0]       lat_tval;
    logic [CNT_W-1:0]      cnt;
    logic                  timeout_flag;
    logic [XLEN-1:0]       mepc, mcause, mtval;
    logic                  mie, mpie;

    logic accept_exc, accept_mret, accept_irq, timeout_hit;

    // Fixed acceptance priority in IDLE: exception, then MRET, then enabled interrupt.
    always_comb begin
        accept_exc  = (state == ST_IDLE) && bus.exc_valid;
        accept_mret = (state == ST_IDLE) && !bus.exc_valid && bus.mret_valid;
        accept_irq  = (state == ST_IDLE) && !bus.exc_valid && !bus.mret_valid &&
                      bus.irq_pending && mie;
        timeout_hit = (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_exc || accept_irq) state_next = ST_DRAIN;
                else if (accept_mret)         state_next = ST_FLUSH;
            end
            ST_DRAIN:    if (bus.lsu_idle || timeout_hit) state_next = ST_FLUSH;
            ST_FLUSH:    state_next = ST_REDIRECT;
            ST_REDIRECT: if (bus.redirect_ready) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Output decode from current state and latched event.
    always_comb begin
        bus.exc_ready      = accept_exc;
        bus.mret_ready     = accept_mret;
        bus.flush_pipeline = (state == ST_FLUSH);
        bus.redirect_valid = (state == ST_REDIRECT);
        bus.redirect_pc    = '0;
        if (state == ST_REDIRECT)
            bus.redirect_pc = (evt == EVT_MRET) ? mepc : (bus.mtvec & ~XLEN'(3));
        bus.trap_busy      = (state != ST_IDLE);
        bus.mepc_o         = mepc;
        bus.mcause_o       = mcause;
        bus.mtval_o        = mtval;
        bus.mstatus_mie_o  = mie;
        bus.mstatus_mpie_o = mpie;
        bus.drain_timeout  = timeout_flag;
    end

    // Event latch, drain counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt          <= EVT_EXC;
            lat_code     <= '0;
            lat_pc       <= '0;
            lat_tval     <= '0;
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (accept_exc) begin
                evt      <= EVT_EXC;
                lat_code <= bus.exc_code;
                lat_pc   <= bus.exc_pc;
                lat_tval <= bus.exc_tval;
                cnt      <= '0;
            end else if (accept_irq) begin
                evt      <= EVT_IRQ;
                lat_code <= EXC_CODE_W'(IRQ_M_EXT_CODE);
                lat_pc   <= bus.commit_pc;
                lat_tval <= '0;
                cnt      <= '0;
            end else if (accept_mret) begin
                evt <= EVT_MRET;
            end else if (state == ST_DRAIN) begin
                cnt <= cnt + CNT_W'(1);
            end
            if ((state == ST_DRAIN) && !bus.lsu_idle && timeout_hit)
                timeout_flag <= 1'b1;
        end
    end

    // Trap CSRs: FLUSH commits the trap/MRET update; software writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
        end else if (state == ST_FLUSH) begin
            if (evt == EVT_MRET) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else begin
                mepc   <= lat_pc;
                mcause <= {(evt == EVT_IRQ), {(XLEN-1-EXC_CODE_W){1'b0}}, lat_code};
                mtval  <= lat_tval;
                mpie   <= mie;
                mie    <= 1'b0;
            end
        end else if ((state == ST_IDLE) && bus.csr_wr_en) begin
            case (bus.csr_wr_sel)
                CSR_SEL_MEPC:   mepc   <= bus.csr_wr_data & ~XLEN'(3);
                CSR_SEL_MCAUSE: mcause <= bus.csr_wr_data & MCAUSE_MASK;
                CSR_SEL_MTVAL:  mtval  <= bus.csr_wr_data;
                default: begin
                    mie  <= bus.csr_wr_data[MSTATUS_MIE_BIT];
                    mpie <= bus.csr_wr_data[MSTATUS_MPIE_BIT];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: scoreboard of expected trap outcomes per event.
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    typedef struct packed {
        logic [15:0] flush_off;
        logic [15:0] redir_off;
        logic [7:0]  flushes;
        logic [7:0]  faults;
        logic [31:0] redirect_pc;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic        mie;
        logic        mpie;
    } result_t;

    logic    clk = 1'b0;
    logic    rst;
    int      checks = 0;
    int      errors = 0;
    bit      model_mie = 1'b0;
    bit      model_mpie = 1'b0;
    result_t exp_q[$];

    trap_sequencer_if #(.XLEN(32), .EXC_CODE_W(5)) bus ();

    trap_sequencer #(.XLEN(32), .EXC_CODE_W(5), .DRAIN_TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.exc_valid      = 1'b0;
        bus.exc_code       = '0;
        bus.exc_pc         = '0;
        bus.exc_tval       = '0;
        bus.irq_pending    = 1'b0;
        bus.commit_pc      = '0;
        bus.mret_valid     = 1'b0;
        bus.lsu_idle       = 1'b1;
        bus.mtvec          = 32'h0000_2001;
        bus.csr_wr_en      = 1'b0;
        bus.csr_wr_sel     = '0;
        bus.csr_wr_data    = '0;
        bus.redirect_ready = 1'b1;
    endtask

    // Expected outcome of an EXC/IRQ trap; advances the MIE/MPIE model.
    task automatic push_trap(input int fo, input int ro, input logic [31:0] pc,
                             input logic [31:0] cause, input logic [31:0] tval);
        result_t e;
        e = '0;
        e.flush_off = 16'(fo);  e.redir_off = 16'(ro);  e.flushes = 8'd1;
        e.redirect_pc = 32'h0000_2000;
        e.mepc = pc;  e.mcause = cause;  e.mtval = tval;
        e.mpie = model_mie;  e.mie = 1'b0;
        model_mpie = model_mie;
        model_mie  = 1'b0;
        exp_q.push_back(e);
    endtask

    // Expected outcome of an MRET; trap fields are left untouched.
    task automatic push_mret(input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] tval);
        result_t e;
        e = '0;
        e.flush_off = 16'd1;  e.redir_off = 16'd2;  e.flushes = 8'd1;
        e.redirect_pc = pc;
        e.mepc = pc;  e.mcause = cause;  e.mtval = tval;
        e.mie = model_mpie;  e.mpie = 1'b1;
        model_mie  = model_mpie;
        model_mpie = 1'b1;
        exp_q.push_back(e);
    endtask

    // Follows one sequence from the accept cycle to the redirect handshake and records
    // what happened; lsu_idle is held low for lsu_low cycles and redirect_ready for
    // ready_delay cycles of REDIRECT. An expired budget leaves redir_off at 0.
    task automatic observe(input int lsu_low, input int ready_delay, input int budget,
                           output result_t obs);
        int          off = 0;
        int          held = 0;
        bit          done = 1'b0;
        logic [31:0] first_pc = '0;
        obs = '0;
        bus.redirect_ready = 1'b0;
        while (!done && off < budget) begin
            @(posedge clk);
            #1;
            off++;
            if (off == 1) begin
                bus.exc_valid   = 1'b0;
                bus.mret_valid  = 1'b0;
                bus.irq_pending = 1'b0;
            end
            bus.lsu_idle = (off > lsu_low);
            #1;
            if (!bus.trap_busy) obs.faults++;
            if (bus.flush_pipeline) begin
                obs.flushes++;
                obs.flush_off = 16'(off);
            end
            if (bus.redirect_valid) begin
                if (held == 0) first_pc = bus.redirect_pc;
                else if (bus.redirect_pc !== first_pc) obs.faults++;
                if (held == ready_delay) begin
                    bus.redirect_ready = 1'b1;
                    obs.redir_off   = 16'(off);
                    obs.redirect_pc = bus.redirect_pc;
                    done = 1'b1;
                end else begin
                    held++;
                end
            end
        end
        bus.lsu_idle = 1'b1;
        bus.redirect_ready = 1'b1;
        // CSR fields settle after the FLUSH edge, which precedes the handshake cycle
        obs.mepc   = bus.mepc_o;
        obs.mcause = bus.mcause_o;
        obs.mtval  = bus.mtval_o;
        obs.mie    = bus.mstatus_mie_o;
        obs.mpie   = bus.mstatus_mpie_o;
    endtask

    task automatic test_reset();
        logic [200:0] outs;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        outs = {bus.trap_busy, bus.flush_pipeline, bus.redirect_valid, bus.redirect_pc,
                bus.mepc_o, bus.mcause_o, bus.mtval_o, bus.mstatus_mie_o,
                bus.mstatus_mpie_o, bus.drain_timeout, bus.exc_ready, bus.mret_ready};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        model_mie = 1'b0;
        model_mpie = 1'b0;
    endtask

    task automatic test_exc_basic();
        result_t obs, e;
        tick();
        bus.exc_valid = 1'b1;  bus.exc_code = 5'd2;
        bus.exc_pc = 32'h100;  bus.exc_tval = 32'h1234_5678;
        #1;
        checks++;
        if (bus.exc_ready !== 1'b1) begin
            errors++;
            $display("FAIL exc_ready: got %b want 1", bus.exc_ready);
        end
        push_trap(2, 3, 32'h100, 32'd2, 32'h1234_5678);
        observe(0, 0, 40, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL exc_basic: got %h want %h", obs, e);
        end
    endtask

    task automatic test_drain_wait();
        result_t obs, e;
        tick();
        bus.exc_valid = 1'b1;  bus.exc_code = 5'd4;
        bus.exc_pc = 32'h108;  bus.exc_tval = 32'h55;
        #1;
        push_trap(7, 8, 32'h108, 32'd4, 32'h55);
        observe(5, 0, 40, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL drain_wait: got %h want %h", obs, e);
        end
        checks++;
        if (bus.drain_timeout !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout_clear: got %b want 0", bus.drain_timeout);
        end
    endtask

    task automatic test_drain_timeout();
        result_t obs, e;
        tick();
        bus.exc_valid = 1'b1;  bus.exc_code = 5'd5;
        bus.exc_pc = 32'h204;  bus.exc_tval = 32'hDEAD;
        #1;
        push_trap(65, 66, 32'h204, 32'd5, 32'hDEAD);
        observe(100000, 0, 200, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL drain_timeout_seq: got %h want %h", obs, e);
        end
        checks++;
        if (bus.drain_timeout !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout_set: got %b want 1", bus.drain_timeout);
        end
    endtask

    task automatic test_irq();
        result_t obs, e;
        int      busy_seen = 0;
        tick();
        bus.irq_pending = 1'b1;
        bus.commit_pc   = 32'h3004;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.trap_busy) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL irq_masked: got %0d busy cycles want 0", busy_seen);
        end
        bus.csr_wr_en = 1'b1;  bus.csr_wr_sel = CSR_SEL_MSTATUS;  bus.csr_wr_data = 32'h8;
        tick();
        bus.csr_wr_en = 1'b0;
        model_mie = 1'b1;
        model_mpie = 1'b0;
        checks++;
        if (bus.mstatus_mie_o !== 1'b1) begin
            errors++;
            $display("FAIL mie_write: got %b want 1", bus.mstatus_mie_o);
        end
        push_trap(2, 3, 32'h3004, IRQ_M_EXT, 32'h0);
        observe(0, 0, 40, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL irq_taken: got %h want %h", obs, e);
        end
    endtask

    task automatic test_priority_mret();
        result_t obs, e;
        tick();
        bus.csr_wr_en = 1'b1;  bus.csr_wr_sel = CSR_SEL_MSTATUS;  bus.csr_wr_data = 32'h8;
        tick();
        bus.csr_wr_en = 1'b0;
        model_mie = 1'b1;
        model_mpie = 1'b0;
        bus.exc_valid = 1'b1;  bus.exc_code = 5'd7;
        bus.exc_pc = 32'h400;  bus.exc_tval = 32'h77;
        bus.mret_valid = 1'b1;  bus.irq_pending = 1'b1;
        #1;
        checks++;
        if ({bus.exc_ready, bus.mret_ready} !== 2'b10) begin
            errors++;
            $display("FAIL priority: got exc/mret ready %b%b want 10",
                     bus.exc_ready, bus.mret_ready);
        end
        push_trap(2, 3, 32'h400, 32'd7, 32'h77);
        observe(0, 0, 40, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL priority_exc: got %h want %h", obs, e);
        end
        tick();
        bus.mret_valid = 1'b1;
        #1;
        checks++;
        if (bus.mret_ready !== 1'b1) begin
            errors++;
            $display("FAIL mret_ready: got %b want 1", bus.mret_ready);
        end
        push_mret(32'h400, 32'd7, 32'h77);
        observe(0, 0, 40, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL mret_seq: got %h want %h", obs, e);
        end
        checks++;
        if (bus.drain_timeout !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout_sticky: got %b want 1", bus.drain_timeout);
        end
    endtask

    task automatic test_csr_write();
        logic [1:0]  sel  [4] = '{CSR_SEL_MEPC, CSR_SEL_MCAUSE, CSR_SEL_MTVAL, CSR_SEL_MSTATUS};
        logic [31:0] data [4] = '{32'h0000_1237, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0000_0080};
        logic [31:0] want [4] = '{32'h0000_1234, 32'h8000_001F, 32'hCAFE_F00D, 32'h0000_0080};
        logic [31:0] got;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            bus.csr_wr_en = 1'b1;  bus.csr_wr_sel = sel[i];  bus.csr_wr_data = data[i];
            tick();
            bus.csr_wr_en = 1'b0;
            case (i)
                0:       got = bus.mepc_o;
                1:       got = bus.mcause_o;
                2:       got = bus.mtval_o;
                default: got = {24'h0, bus.mstatus_mpie_o, 3'b000, bus.mstatus_mie_o, 3'b000};
            endcase
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL csr_write[%0d]: got %h want %h", i, got, want[i]);
            end
        end
        model_mie = 1'b0;
        model_mpie = 1'b1;
        // An MRET leaves the trap fields alone, so a write during FLUSH must not land.
        tick();
        bus.mret_valid = 1'b1;
        tick();
        bus.mret_valid = 1'b0;
        bus.csr_wr_en = 1'b1;  bus.csr_wr_sel = CSR_SEL_MTVAL;  bus.csr_wr_data = 32'hBAD;
        tick();
        bus.csr_wr_en = 1'b0;
        tick();
        checks++;
        if ({bus.mtval_o, bus.mstatus_mie_o, bus.mstatus_mpie_o} !== {32'hCAFE_F00D, 2'b11}) begin
            errors++;
            $display("FAIL csr_busy_ignored: got mtval %h mie %b mpie %b want cafef00d 1 1",
                     bus.mtval_o, bus.mstatus_mie_o, bus.mstatus_mpie_o);
        end
        model_mie = 1'b1;
        model_mpie = 1'b1;
    endtask

    task automatic test_redirect_stall();
        result_t obs, e;
        tick();
        bus.exc_valid = 1'b1;  bus.exc_code = 5'd1;
        bus.exc_pc = 32'h500;  bus.exc_tval = 32'h0;
        #1;
        push_trap(2, 6, 32'h500, 32'd1, 32'h0);
        observe(0, 3, 40, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL redirect_stall: got %h want %h", obs, e);
        end
    endtask

    task automatic test_rst_in_drain();
        logic [200:0] outs;
        int           redirects = 0;
        tick();
        bus.exc_valid = 1'b1;  bus.exc_code = 5'd3;  bus.exc_pc = 32'h600;
        bus.lsu_idle = 1'b0;
        tick();
        bus.exc_valid = 1'b0;
        tick();
        checks++;
        if (bus.trap_busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_busy: got %b want 1", bus.trap_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.lsu_idle = 1'b1;
        #1;
        outs = {bus.trap_busy, bus.flush_pipeline, bus.redirect_valid, bus.redirect_pc,
                bus.mepc_o, bus.mcause_o, bus.mtval_o, bus.mstatus_mie_o,
                bus.mstatus_mpie_o, bus.drain_timeout, bus.exc_ready, bus.mret_ready};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_in_drain: got %h want 0", outs);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.redirect_valid || bus.flush_pipeline) redirects++;
        end
        checks++;
        if (redirects != 0) begin
            errors++;
            $display("FAIL rst_no_redirect: got %0d redirect/flush cycles want 0", redirects);
        end
    endtask

    initial begin
        test_reset();
        test_exc_basic();
        test_drain_wait();
        test_drain_timeout();
        test_irq();
        test_priority_mret();
        test_csr_write();
        test_redirect_stall();
        test_rst_in_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
